// File: rtl/riscv_regfile_lsx_if.sv
// Register-file bus: read ports, store operand formatting, write-back and load scoreboard.
// The master side is the pipeline (decode/write-back); the slave side is the register file.
interface riscv_regfile_lsx_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned LW = $clog2(BW);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic [2:0]      st_funct3;
  logic [LW-1:0]   st_addr_lo;
  logic [XLEN-1:0] st_wdata;
  logic [BW-1:0]   st_be;
  logic            st_misalign;

  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_load;
  logic [2:0]      wb_funct3;
  logic [LW-1:0]   wb_addr_lo;

  logic            pend_set;
  logic [AW-1:0]   pend_rd;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output rs1_addr, rs2_addr, st_funct3, st_addr_lo,
    output wb_valid, wb_rd, wb_data, wb_load, wb_funct3, wb_addr_lo,
    output pend_set, pend_rd,
    input  rs1_data, rs2_data, st_wdata, st_be, st_misalign, rs1_busy, rs2_busy
  );

  modport slave (
    input  rs1_addr, rs2_addr, st_funct3, st_addr_lo,
    input  wb_valid, wb_rd, wb_data, wb_load, wb_funct3, wb_addr_lo,
    input  pend_set, pend_rd,
    output rs1_data, rs2_data, st_wdata, st_be, st_misalign, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/riscv_regfile_lsx.sv
// Integer register file with load-result formatting, store lane alignment,
// optional write-to-read bypass and a per-register pending-load scoreboard.
module riscv_regfile_lsx #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input logic                clk,
  input logic                reset,
  riscv_regfile_lsx_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned BW = XLEN / 8;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] wb_shift, wb_fmt;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hit1, hit2;
  logic [BW-1:0]   size_mask;
  logic            misalign;

  // Keep the low 8*nbytes bits of v; fill the rest with the slice MSB or zero.
  function automatic logic [XLEN-1:0] ext(logic [XLEN-1:0] v, int unsigned nbytes,
                                          logic sgn);
    logic [XLEN-1:0] r;
    logic            msb;
    msb = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == 8 * nbytes - 1) msb = v[i];
    end
    r = {XLEN{msb & sgn}};
    for (int i = 0; i < XLEN; i++) begin
      if (i < 8 * nbytes) r[i] = v[i];
    end
    return r;
  endfunction

  always_comb begin
    wb_shift = bus.wb_data >> {bus.wb_addr_lo, 3'b000};
    wb_fmt   = bus.wb_data;
    if (bus.wb_load) begin
      unique case (bus.wb_funct3)
        3'b000:  wb_fmt = ext(wb_shift, 1, 1'b1);
        3'b001:  wb_fmt = ext(wb_shift, 2, 1'b1);
        3'b010:  wb_fmt = ext(wb_shift, 4, 1'b1);
        3'b011:  wb_fmt = (XLEN == 64) ? wb_shift : ext(wb_shift, 4, 1'b1);
        3'b100:  wb_fmt = ext(wb_shift, 1, 1'b0);
        3'b101:  wb_fmt = ext(wb_shift, 2, 1'b0);
        3'b110:  wb_fmt = ext(wb_shift, 4, (XLEN == 64) ? 1'b0 : 1'b1);
        default: wb_fmt = wb_shift;
      endcase
    end
  end

  always_comb begin
    hit1    = (BYPASS != 0) && bus.wb_valid && (bus.wb_rd == bus.rs1_addr);
    hit2    = (BYPASS != 0) && bus.wb_valid && (bus.wb_rd == bus.rs2_addr);
    rs1_val = (bus.rs1_addr == '0) ? '0 : (hit1 ? wb_fmt : regs_q[bus.rs1_addr]);
    rs2_val = (bus.rs2_addr == '0) ? '0 : (hit2 ? wb_fmt : regs_q[bus.rs2_addr]);
    bus.rs1_data = rs1_val;
    bus.rs2_data = rs2_val;
    // A load landing this cycle is already forwarded, so its hazard is hidden.
    bus.rs1_busy = busy_q[bus.rs1_addr] & ~(hit1 & bus.wb_load);
    bus.rs2_busy = busy_q[bus.rs2_addr] & ~(hit2 & bus.wb_load);
  end

  // SD on a 32-bit core degenerates to SW: '1 is then four lanes and any nonzero offset faults.
  always_comb begin
    size_mask = '0;
    misalign  = 1'b0;
    unique case (bus.st_funct3)
      3'b000:  size_mask = BW'(1);
      3'b001: begin
        size_mask = BW'(3);
        misalign  = bus.st_addr_lo[0];
      end
      3'b010: begin
        size_mask = BW'(15);
        misalign  = (bus.st_addr_lo[1:0] != 2'b00);
      end
      3'b011: begin
        size_mask = '1;
        misalign  = (bus.st_addr_lo != '0);
      end
      default: size_mask = '0;
    endcase
    bus.st_misalign = misalign;
    bus.st_be       = misalign ? '0 : (size_mask << bus.st_addr_lo);
    bus.st_wdata    = rs2_val << {bus.st_addr_lo, 3'b000};
  end

  // Set after clear so a new load to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid && bus.wb_load) busy_d[bus.wb_rd] = 1'b0;
    if (bus.pend_set && (bus.pend_rd != '0)) busy_d[bus.pend_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (bus.wb_valid && (bus.wb_rd != AW'(0))) regs_q[bus.wb_rd] <= wb_fmt;
    end
  end
endmodule

// File: tb/tb_riscv_regfile_lsx.sv
// Scoreboard bench for riscv_regfile_lsx (XLEN=32, NREG=32, BYPASS=1): directed cases
// followed by random traffic, expectations from an arithmetic reference model.
module tb_riscv_regfile_lsx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_regfile_lsx_if #(.XLEN(32), .NREG(32)) bus ();

  riscv_regfile_lsx #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] stw;
    logic [3:0]  be;
    logic        mis;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_regs[32];
  bit          m_busy[32];

  // Load result from first principles: extract nbytes at byte offset, then extend.
  function automatic logic [31:0] m_fmt(bit load, int f3, int lo, logic [31:0] d);
    longint unsigned s, v, lim;
    int nb;
    bit sgn;
    if (!load) return d;
    case (f3)
      0: begin nb = 1; sgn = 1; end
      1: begin nb = 2; sgn = 1; end
      4: begin nb = 1; sgn = 0; end
      5: begin nb = 2; sgn = 0; end
      default: begin nb = 4; sgn = 1; end
    endcase
    s   = longint'(d) >> (8 * lo);
    lim = 64'd1 << (8 * nb);
    v   = s % lim;
    if (sgn && (v >= lim / 2)) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_read(int a, bit wbv, int wrd, logic [31:0] wf);
    if (a == 0) return 32'h0;
    if (wbv && wrd == a) return wf;
    return m_regs[a];
  endfunction

  task automatic chk(string tag, string nm, logic [31:0] act, logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h want %h", tag, nm, act, want);
    end
  endtask

  task automatic drive(string tag, bit rst, int r1, int r2, int sf3, int slo, bit wbv,
                       int wrd, logic [31:0] wd, bit wl, int wf3, int wlo, bit ps, int prd);
    exp_t        x;
    logic [31:0] wf;
    int          n;
    reset          = rst;
    bus.rs1_addr   = 5'(r1);
    bus.rs2_addr   = 5'(r2);
    bus.st_funct3  = 3'(sf3);
    bus.st_addr_lo = 2'(slo);
    bus.wb_valid   = wbv;
    bus.wb_rd      = 5'(wrd);
    bus.wb_data    = wd;
    bus.wb_load    = wl;
    bus.wb_funct3  = 3'(wf3);
    bus.wb_addr_lo = 2'(wlo);
    bus.pend_set   = ps;
    bus.pend_rd    = 5'(prd);
    wf    = m_fmt(wl, wf3, wlo, wd);
    x.tag = tag;
    x.rs1 = m_read(r1, wbv, wrd, wf);
    x.rs2 = m_read(r2, wbv, wrd, wf);
    x.b1  = m_busy[r1] && !(wbv && wl && wrd == r1);
    x.b2  = m_busy[r2] && !(wbv && wl && wrd == r2);
    n     = (sf3 == 3) ? 4 : (1 << sf3);
    x.mis = (slo % n) != 0;
    x.be  = x.mis ? 4'h0 : 4'((((1 << n) - 1) << slo) % 16);
    x.stw = 32'(longint'(x.rs2) << (8 * slo));
    q.push_back(x);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 0;
      end
    end else begin
      if (wbv && wrd != 0) m_regs[wrd] = wf;
      if (wbv && wl) m_busy[wrd] = 0;
      if (ps && prd != 0) m_busy[prd] = 1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, "rs1_data", bus.rs1_data, e.rs1);
      chk(e.tag, "rs2_data", bus.rs2_data, e.rs2);
      chk(e.tag, "rs1_busy", 32'(bus.rs1_busy), 32'(e.b1));
      chk(e.tag, "rs2_busy", 32'(bus.rs2_busy), 32'(e.b2));
      chk(e.tag, "st_wdata", bus.st_wdata, e.stw);
      chk(e.tag, "st_be", 32'(bus.st_be), 32'(e.be));
      chk(e.tag, "st_misalign", 32'(bus.st_misalign), 32'(e.mis));
    end
  end

  initial begin
    reset = 1'b1;
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.st_funct3 = '0; bus.st_addr_lo = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.wb_load = 1'b0;
    bus.wb_funct3 = '0; bus.wb_addr_lo = '0; bus.pend_set = 1'b0; bus.pend_rd = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) drive("reset_rd", 0, i, 31 - i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive("alu_x5", 0, 5, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    drive("rd_x5", 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("wb_x0", 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    drive("rd_x0", 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("lb_x6", 0, 0, 0, 0, 0, 1, 6, 32'h0000_8000, 1, 0, 1, 0, 0);
    drive("rd_lb", 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("lbu_x6", 0, 0, 0, 0, 0, 1, 6, 32'h0000_8000, 1, 4, 1, 0, 0);
    drive("rd_lbu", 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("lh_x6", 0, 0, 0, 0, 0, 1, 6, 32'h7FFF_0000, 1, 1, 2, 0, 0);
    drive("rd_lh", 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("byp_x7", 0, 0, 7, 0, 0, 1, 7, 32'h55, 0, 0, 0, 0, 0);
    drive("wr_x8", 0, 0, 0, 0, 0, 1, 8, 32'h1122_3344, 0, 0, 0, 0, 0);
    drive("sb_lo3", 0, 0, 8, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("sh_lo1", 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("sw_lo0", 0, 0, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("sd_lo2", 0, 0, 8, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("pend_x9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    drive("busy_x9", 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("set_clr", 0, 9, 0, 0, 0, 1, 9, 32'hAB, 1, 2, 0, 1, 9);
    drive("busy_keep", 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("rst_mid", 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("busy_rst", 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("ld_nobusy", 0, 0, 0, 0, 0, 1, 9, 32'hF00D, 1, 5, 0, 0, 0);
    drive("rd_nobusy", 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 600; k++) begin
      int r1, r2, wrd, prd;
      r1  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      r2  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      wrd = $urandom_range(0, 7);
      prd = $urandom_range(0, 7);
      drive("rand", $urandom_range(0, 59) == 0, r1, r2, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), wrd, $urandom,
            $urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, prd);
    end

    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
